// File: rtl/flexbex_ibex_rf_context_engine.sv
// flexbex_ibex_rf_context_engine
//
// Moves registers x1..xLAST between the core register file and data memory,
// one register at a time, while the pipeline is halted. A save copies the
// registers out to memory. A restore reloads them from memory. x0 is never
// read or written.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_save_i        one-cycle request to start a save (wins over restore)
//   start_restore_i     one-cycle request to start a restore
//   base_addr_i         memory base address, word aligned when captured at start
//   busy_o              transfer in progress (REQ, WAIT_RV, DONE)
//   done_o              one-cycle completion pulse
//   rf_raddr_o          register file read port address (save mode, REQ only)
//   rf_rdata_i          register file read data, combinational from rf_raddr_o
//   rf_waddr_o          register file write address
//   rf_wdata_o          register file write data
//   rf_we_o             register file write enable (restore mode, on rvalid)
//   data_req_o          bus request
//   data_gnt_i          bus grant
//   data_rvalid_i       bus response valid
//   data_we_o           bus write (1) / read (0)
//   data_be_o           byte enables, all ones while requesting
//   data_addr_o         bus address, base + 4*idx
//   data_wdata_o        bus write data
//   data_rdata_i        bus read data

module flexbex_ibex_rf_context_engine #(
    parameter bit RV32E      = 1'b0,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_save_i,
    input  logic                  start_restore_i,
    input  logic [31:0]           base_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4:0]            rf_raddr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i,
    output logic [4:0]            rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  rf_we_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_addr_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic [DATA_WIDTH-1:0] data_rdata_i
);

    localparam logic [4:0] LAST_IDX = RV32E ? 5'd15 : 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RV,
        DONE
    } state_e;

    state_e      state, state_next;
    logic [4:0]  idx, idx_next;
    logic        mode_save, mode_save_next;
    logic [31:0] base, base_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 5'd1;
            mode_save <= 1'b1;
            base      <= 32'd0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            mode_save <= mode_save_next;
            base      <= base_next;
        end
    end

    always_comb begin
        state_next     = state;
        idx_next       = idx;
        mode_save_next = mode_save;
        base_next      = base;

        busy_o       = 1'b0;
        done_o       = 1'b0;
        rf_raddr_o   = 5'd0;
        rf_waddr_o   = 5'd0;
        rf_wdata_o   = '0;
        rf_we_o      = 1'b0;
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_be_o    = 4'h0;
        data_addr_o  = 32'd0;
        data_wdata_o = '0;

        case (state)
            IDLE: begin
                // Save has priority when both starts arrive together.
                if (start_save_i || start_restore_i) begin
                    base_next      = base_addr_i & 32'hFFFF_FFFC;
                    idx_next       = 5'd1;
                    mode_save_next = start_save_i;
                    state_next     = REQ;
                end
            end

            REQ: begin
                // Everything here is a function of registered state, so the
                // request stays stable until the grant arrives.
                busy_o      = 1'b1;
                data_req_o  = 1'b1;
                data_we_o   = mode_save;
                data_be_o   = 4'hF;
                data_addr_o = base + {25'd0, idx, 2'b00};
                if (mode_save) begin
                    rf_raddr_o   = idx;
                    data_wdata_o = rf_rdata_i;
                end
                if (data_gnt_i) begin
                    state_next = WAIT_RV;
                end
            end

            WAIT_RV: begin
                busy_o = 1'b1;
                if (data_rvalid_i) begin
                    if (!mode_save) begin
                        rf_we_o    = 1'b1;
                        rf_waddr_o = idx;
                        rf_wdata_o = data_rdata_i;
                    end
                    if (idx == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx + 5'd1;
                        state_next = REQ;
                    end
                end
            end

            DONE: begin
                busy_o     = 1'b1;
                done_o     = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_flexbex_ibex_rf_context_engine.sv
// tb_flexbex_ibex_rf_context_engine
//
// Self-checking bench for flexbex_ibex_rf_context_engine. Two instances are
// used: one with 32 registers and one with RV32E (16 registers). A select
// flag picks which one a test is driving. The other instance never sees a
// start, so it stays idle and ignores the shared bus inputs. The reference
// model is a register file array plus a sparse memory, and the expected
// transaction list is k = 1..LAST at address (base & ~3) + 4k.

module tb_flexbex_ibex_rf_context_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_save, start_restore;
    logic        sel_e;
    logic [31:0] base;
    logic        gnt, rvalid;
    logic [31:0] rdata, rf_rdata;

    logic        busy_f, done_f, rf_we_f, req_f, we_f;
    logic [4:0]  raddr_f, waddr_f;
    logic [3:0]  be_f;
    logic [31:0] rf_wdata_f, addr_f, wdata_f;
    logic        busy_e, done_e, rf_we_e, req_e, we_e;
    logic [4:0]  raddr_e, waddr_e;
    logic [3:0]  be_e;
    logic [31:0] rf_wdata_e, addr_e, wdata_e;

    logic        busy, done, rf_we, req, we;
    logic [4:0]  raddr, waddr;
    logic [3:0]  be;
    logic [31:0] rf_wdata, addr, wdata;

    assign busy     = sel_e ? busy_e     : busy_f;
    assign done     = sel_e ? done_e     : done_f;
    assign rf_we    = sel_e ? rf_we_e    : rf_we_f;
    assign req      = sel_e ? req_e      : req_f;
    assign we       = sel_e ? we_e       : we_f;
    assign raddr    = sel_e ? raddr_e    : raddr_f;
    assign waddr    = sel_e ? waddr_e    : waddr_f;
    assign be       = sel_e ? be_e       : be_f;
    assign rf_wdata = sel_e ? rf_wdata_e : rf_wdata_f;
    assign addr     = sel_e ? addr_e     : addr_f;
    assign wdata    = sel_e ? wdata_e    : wdata_f;

    logic [31:0] rf_model [32];
    logic [31:0] mem [logic [31:0]];

    assign rf_rdata = rf_model[raddr];

    flexbex_ibex_rf_context_engine #(.RV32E(1'b0), .DATA_WIDTH(32)) dut_full (
        .clk(clk), .rst_n(rst_n),
        .start_save_i(start_save & ~sel_e), .start_restore_i(start_restore & ~sel_e),
        .base_addr_i(base), .busy_o(busy_f), .done_o(done_f),
        .rf_raddr_o(raddr_f), .rf_rdata_i(rf_rdata),
        .rf_waddr_o(waddr_f), .rf_wdata_o(rf_wdata_f), .rf_we_o(rf_we_f),
        .data_req_o(req_f), .data_gnt_i(gnt), .data_rvalid_i(rvalid),
        .data_we_o(we_f), .data_be_o(be_f), .data_addr_o(addr_f),
        .data_wdata_o(wdata_f), .data_rdata_i(rdata)
    );

    flexbex_ibex_rf_context_engine #(.RV32E(1'b1), .DATA_WIDTH(32)) dut_e (
        .clk(clk), .rst_n(rst_n),
        .start_save_i(start_save & sel_e), .start_restore_i(start_restore & sel_e),
        .base_addr_i(base), .busy_o(busy_e), .done_o(done_e),
        .rf_raddr_o(raddr_e), .rf_rdata_i(rf_rdata),
        .rf_waddr_o(waddr_e), .rf_wdata_o(rf_wdata_e), .rf_we_o(rf_we_e),
        .data_req_o(req_e), .data_gnt_i(gnt), .data_rvalid_i(rvalid),
        .data_we_o(we_e), .data_be_o(be_e), .data_addr_o(addr_e),
        .data_wdata_o(wdata_e), .data_rdata_i(rdata)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    string tname;

    // Results of the most recent transfer.
    int          res_lat;
    int          res_nwr;
    int          res_nbus;
    logic [31:0] res_addr [32];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    // Drives one complete transfer cycle by cycle, acting as the bus slave
    // and checking every output against the expected transaction k.
    task automatic run_transfer(input bit save, input bit both, input logic [31:0] b,
                                input int gmin, input int gmax, input int rmin,
                                input int rmax, input int abort_k);
        int          last_k, k, gw, rw, cyc;
        bit          outst, exp_done, fin;
        logic        exp_req, exp_rfwe;
        logic [31:0] ab, ea;
        last_k   = sel_e ? 15 : 31;
        ab       = b & 32'hFFFF_FFFC;
        res_lat  = -1;
        res_nwr  = 0;
        res_nbus = 0;
        for (int i = 0; i < 32; i++) res_addr[i] = 32'hDEAD_BEEF;

        @(negedge clk);
        base          = b;
        start_save    = save | both;
        start_restore = ~save | both;
        gnt           = 1'b0;
        rvalid        = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL %s busy_before_start: got %b want 0", tname, busy);
        end
        @(posedge clk);

        k = 1; outst = 0; exp_done = 0; fin = 0; cyc = 0; rw = 0;
        gw = $urandom_range(gmax, gmin);
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (cyc > 4000) begin
                n_cmp++; n_err++;
                $display("[TB] FAIL %s timeout: no done after %0d cycles", tname, cyc);
                break;
            end
            base          = $urandom;
            start_save    = ($urandom_range(7, 0) == 0);
            start_restore = ($urandom_range(7, 0) == 0);
            gnt           = 1'b0;
            rvalid        = 1'b0;
            rdata         = $urandom;
            ea            = ab + 32'(k * 4);

            if (abort_k != 0 && k == abort_k && outst) begin
                rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({busy, done, req, rf_we, we} !== 5'b0) begin
                    n_err++;
                    $display("[TB] FAIL %s abort_ctrl: got %b want 00000", tname, {busy, done, req, rf_we, we});
                end
                n_cmp++;
                if ({addr, wdata, rf_wdata} !== 96'd0) begin
                    n_err++;
                    $display("[TB] FAIL %s abort_data: got %h want 0", tname, {addr, wdata, rf_wdata});
                end
                n_cmp++;
                if ({raddr, waddr, be} !== 14'd0) begin
                    n_err++;
                    $display("[TB] FAIL %s abort_addr: got %h want 0", tname, {raddr, waddr, be});
                end
                @(posedge clk);
                @(negedge clk);
                start_save    = 1'b0;
                start_restore = 1'b0;
                rst_n         = 1'b1;
                return;
            end

            if (outst) begin
                gnt = $urandom_range(1, 0);
                if (rw == 0) begin
                    rvalid = 1'b1;
                    rdata  = save ? $urandom : mem_read(ea);
                end else begin
                    rw--;
                end
            end else if (!exp_done) begin
                if (gw == 0) gnt = 1'b1;
                else gw--;
            end
            #1;

            exp_req  = !outst && !exp_done;
            exp_rfwe = !save && rvalid;
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL %s busy k=%0d: got %b want 1", tname, k, busy);
            end
            n_cmp++;
            if (done !== exp_done) begin
                n_err++;
                $display("[TB] FAIL %s done k=%0d: got %b want %b", tname, k, done, exp_done);
            end
            n_cmp++;
            if (req !== exp_req) begin
                n_err++;
                $display("[TB] FAIL %s req k=%0d: got %b want %b", tname, k, req, exp_req);
            end
            if (exp_req) begin
                n_cmp++;
                if (we !== save || be !== 4'hF) begin
                    n_err++;
                    $display("[TB] FAIL %s we_be k=%0d: got %b/%h want %b/f", tname, k, we, be, save);
                end
                n_cmp++;
                if (addr !== ea) begin
                    n_err++;
                    $display("[TB] FAIL %s addr k=%0d: got %h want %h", tname, k, addr, ea);
                end
                if (save) begin
                    n_cmp++;
                    if (wdata !== rf_model[k] || raddr !== 5'(k)) begin
                        n_err++;
                        $display("[TB] FAIL %s save_data k=%0d: got %h@%0d want %h@%0d", tname, k, wdata, raddr, rf_model[k], k);
                    end
                end
            end else begin
                n_cmp++;
                if (addr !== 32'd0 || wdata !== 32'd0 || be !== 4'h0) begin
                    n_err++;
                    $display("[TB] FAIL %s idle_bus k=%0d: got %h/%h/%h want 0", tname, k, addr, wdata, be);
                end
            end
            n_cmp++;
            if (rf_we !== exp_rfwe) begin
                n_err++;
                $display("[TB] FAIL %s rf_we k=%0d: got %b want %b", tname, k, rf_we, exp_rfwe);
            end
            if (rf_we === 1'b1) res_nwr++;
            if (exp_rfwe) begin
                n_cmp++;
                if (waddr !== 5'(k) || rf_wdata !== mem_read(ea)) begin
                    n_err++;
                    $display("[TB] FAIL %s rf_write k=%0d: got %h@%0d want %h@%0d", tname, k, rf_wdata, waddr, mem_read(ea), k);
                end
            end
            if (exp_done) begin
                res_lat = cyc;
                fin     = 1;
            end

            if (!outst && !exp_done) begin
                if (gnt) begin
                    outst            = 1;
                    rw               = $urandom_range(rmax, rmin);
                    res_nbus++;
                    res_addr[k]      = addr;
                    if (save) mem[ea] = rf_model[k];
                end
            end else if (outst && rvalid) begin
                outst = 0;
                if (!save) rf_model[k] = mem_read(ea);
                if (k == last_k) begin
                    exp_done = 1;
                end else begin
                    k++;
                    gw = $urandom_range(gmax, gmin);
                end
            end
            @(posedge clk);
        end

        @(negedge clk);
        start_save    = 1'b0;
        start_restore = 1'b0;
        gnt           = 1'b0;
        rvalid        = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || req !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL %s after_done: got busy=%b done=%b req=%b want 0", tname, busy, done, req);
        end
    endtask

    task automatic test_reset();
        tname = "reset";
        rst_n = 1'b1; start_save = 0; start_restore = 0; base = 0;
        gnt = 0; rvalid = 0; rdata = 0; sel_e = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel_e = s[0];
            #1;
            n_cmp++;
            if ({busy, done, req, rf_we, we} !== 5'b0) begin
                n_err++;
                $display("[TB] FAIL reset_ctrl sel=%0d: got %b want 00000", s, {busy, done, req, rf_we, we});
            end
            n_cmp++;
            if ({addr, wdata, rf_wdata} !== 96'd0) begin
                n_err++;
                $display("[TB] FAIL reset_data sel=%0d: got %h want 0", s, {addr, wdata, rf_wdata});
            end
            n_cmp++;
            if ({raddr, waddr, be} !== 14'd0) begin
                n_err++;
                $display("[TB] FAIL reset_addr sel=%0d: got %h want 0", s, {raddr, waddr, be});
            end
        end
        sel_e = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_save_zero_wait();
        tname = "save_zero_wait";
        sel_e = 0;
        for (int i = 1; i < 32; i++) rf_model[i] = 32'h1000_0000 + 32'(i);
        run_transfer(1, 0, 32'h0000_2000, 0, 0, 0, 0, 0);
        n_cmp++;
        if (res_lat !== 63) begin
            n_err++;
            $display("[TB] FAIL save_latency: got %0d want 63", res_lat);
        end
        n_cmp++;
        if (res_nbus !== 31 || res_nwr !== 0) begin
            n_err++;
            $display("[TB] FAIL save_counts: got bus=%0d rfwr=%0d want 31/0", res_nbus, res_nwr);
        end
        n_cmp++;
        if (res_addr[1] !== 32'h0000_2004 || res_addr[31] !== 32'h0000_207C) begin
            n_err++;
            $display("[TB] FAIL save_range: got %h..%h want 00002004..0000207c", res_addr[1], res_addr[31]);
        end
        n_cmp++;
        if (mem[32'h0000_2010] !== 32'h1000_0004) begin
            n_err++;
            $display("[TB] FAIL save_mem_x4: got %h want 10000004", mem[32'h0000_2010]);
        end
    endtask

    task automatic test_restore_stalls();
        tname = "restore_stalls";
        sel_e = 0;
        for (int i = 1; i < 32; i++) mem[32'h3000 + 32'(4 * i)] = 32'hA5A5_0000 | 32'(i);
        run_transfer(0, 0, 32'h0000_3000, 2, 2, 3, 3, 0);
        n_cmp++;
        if (res_nwr !== 31) begin
            n_err++;
            $display("[TB] FAIL restore_rf_writes: got %0d want 31", res_nwr);
        end
        n_cmp++;
        if (rf_model[31] !== 32'hA5A5_001F || res_addr[31] !== 32'h0000_307C) begin
            n_err++;
            $display("[TB] FAIL restore_last: got %h@%h want a5a5001f@0000307c", rf_model[31], res_addr[31]);
        end
    endtask

    task automatic test_simultaneous_start();
        tname = "simultaneous_start";
        sel_e = 0;
        run_transfer(1, 1, $urandom, 0, 3, 0, 3, 0);
        n_cmp++;
        if (res_nbus !== 31 || res_nwr !== 0) begin
            n_err++;
            $display("[TB] FAIL both_start_counts: got bus=%0d rfwr=%0d want 31/0", res_nbus, res_nwr);
        end
    endtask

    task automatic test_addr_wrap();
        tname = "addr_wrap";
        sel_e = 0;
        run_transfer(1, 0, 32'hFFFF_FFF3, 0, 2, 0, 2, 0);
        n_cmp++;
        if (res_addr[1] !== 32'hFFFF_FFF4) begin
            n_err++;
            $display("[TB] FAIL wrap_first: got %h want fffffff4", res_addr[1]);
        end
        n_cmp++;
        if (res_addr[3] !== 32'hFFFF_FFFC || res_addr[4] !== 32'h0000_0000) begin
            n_err++;
            $display("[TB] FAIL wrap_cross: got %h,%h want fffffffc,00000000", res_addr[3], res_addr[4]);
        end
    endtask

    task automatic test_spurious_and_reset();
        logic [31:0] b;
        tname = "spurious_and_reset";
        sel_e = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rvalid = 1'b1;
            gnt    = $urandom_range(1, 0);
            rdata  = $urandom;
            #1;
            n_cmp++;
            if (rf_we !== 1'b0 || busy !== 1'b0 || req !== 1'b0 || waddr !== 5'd0) begin
                n_err++;
                $display("[TB] FAIL stray_rvalid c=%0d: got we=%b busy=%b req=%b want 0", c, rf_we, busy, req);
            end
        end
        @(negedge clk);
        rvalid = 1'b0;
        gnt    = 1'b0;
        run_transfer(0, 0, 32'h0000_5000, 0, 2, 0, 2, 7);
        n_cmp++;
        if (res_nwr !== 6) begin
            n_err++;
            $display("[TB] FAIL abort_rf_writes: got %0d want 6", res_nwr);
        end
        b = $urandom;
        tname = "after_reset";
        run_transfer(1, 0, b, 0, 0, 0, 0, 0);
        n_cmp++;
        if (res_addr[1] !== (b & 32'hFFFF_FFFC) + 32'd4 || res_lat !== 63) begin
            n_err++;
            $display("[TB] FAIL restart_idx1: got %h lat=%0d want %h lat=63", res_addr[1], res_lat, (b & 32'hFFFF_FFFC) + 32'd4);
        end
    endtask

    task automatic test_rv32e_restore();
        logic [31:0] b;
        tname = "rv32e_restore";
        sel_e = 1;
        b = $urandom;
        run_transfer(0, 0, b, 0, 0, 0, 0, 0);
        n_cmp++;
        if (res_lat !== 31 || res_nbus !== 15 || res_nwr !== 15) begin
            n_err++;
            $display("[TB] FAIL rv32e_counts: got lat=%0d bus=%0d rfwr=%0d want 31/15/15", res_lat, res_nbus, res_nwr);
        end
        n_cmp++;
        if (res_addr[15] !== (b & 32'hFFFF_FFFC) + 32'h3C) begin
            n_err++;
            $display("[TB] FAIL rv32e_last_addr: got %h want %h", res_addr[15], (b & 32'hFFFF_FFFC) + 32'h3C);
        end
        sel_e = 0;
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 6; t++) begin
            tname = "back_to_back";
            sel_e = $urandom_range(1, 0);
            run_transfer($urandom_range(1, 0), 0, $urandom, 0, 3, 0, 3, 0);
        end
        sel_e = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = (i == 0) ? 32'd0 : $urandom;
        test_reset();
        test_save_zero_wait();
        test_restore_stalls();
        test_simultaneous_start();
        test_addr_wrap();
        test_spurious_and_reset();
        test_rv32e_restore();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
